// File: rtl/list_if_pkg.sv
// Shared definitions for the dfd_* list-output interface and its consumers.
//   - Default data/sum/count widths reused by list producers and the reducer.
//   - Reducer state encoding (3 bits).
package list_if_pkg;

    localparam int unsigned LIST_DATA_W = 8;
    localparam int unsigned LIST_SUM_W  = 16;
    localparam int unsigned LIST_CNT_W  = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StGap  = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4
    } list_state_e;

endpackage

// File: rtl/list_ack_watchdog.sv
// Per-request ack timer for the list reducer.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous clear of the timer (has priority over enable)
//   enable       : count up by one this cycle
//   expired      : timer has reached TIMEOUT
module list_ack_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = (timer == TW'(TIMEOUT));

endmodule

// File: rtl/list_stream_reducer.sv
// Consumer for the req/ack list interface of dfd_* blocks. A rising edge on
// start pulls elements one at a time and reduces them to count, wrapping sum
// and unsigned maximum, ending in DONE (end-of-list) or ERR (stall, protocol
// violation or count overflow).
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   start             : level input; a sampled rising edge begins a reduction
//   list_req          : element request to the producer
//   list_ack          : one-cycle producer response
//   list_value        : element data (valid with list_ack & list_value_valid)
//   list_value_valid  : with list_ack, 1 = element, 0 = end of list
//   done, error       : result valid / error flags
//   count, sum, max_val : reduction results
module list_stream_reducer
    import list_if_pkg::*;
#(
    parameter int unsigned DATA_W  = LIST_DATA_W,
    parameter int unsigned SUM_W   = LIST_SUM_W,
    parameter int unsigned CNT_W   = LIST_CNT_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              list_req,
    input  logic              list_ack,
    input  logic [DATA_W-1:0] list_value,
    input  logic              list_value_valid,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  count,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_val
);

    list_state_e state;
    logic        start_q;
    logic        start_edge;
    logic        start_go;
    logic        wd_clear;
    logic        wd_enable;
    logic        expired;

    assign start_edge = start & ~start_q;

    // Start edges only matter when no list transfer is in flight.
    assign start_go = start_edge &
                      ((state == StIdle) || (state == StDone) || (state == StErr));

    // Timer restarts per request: any ack ends the current request.
    assign wd_clear  = start_go | ((state == StReq) & list_ack);
    assign wd_enable = (state == StReq) & ~list_ack & ~expired;

    list_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            start_q  <= 1'b0;
            list_req <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            max_val  <= '0;
        end else begin
            start_q <= start;
            unique case (state)
                StIdle, StDone, StErr: begin
                    if (start_go) begin
                        state    <= StReq;
                        list_req <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        count    <= '0;
                        sum      <= '0;
                        max_val  <= '0;
                    end
                end
                StReq: begin
                    // An ack in the timeout cycle still counts as a response.
                    if (list_ack) begin
                        list_req <= 1'b0;
                        if (!list_value_valid) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else if (count == '1) begin
                            // Counter would wrap: drop the element, flag it.
                            state <= StErr;
                            error <= 1'b1;
                        end else begin
                            state <= StGap;
                            count <= count + CNT_W'(1);
                            sum   <= sum + SUM_W'(list_value);
                            if (list_value > max_val) begin
                                max_val <= list_value;
                            end
                        end
                    end else if (expired) begin
                        list_req <= 1'b0;
                        state    <= StErr;
                        error    <= 1'b1;
                    end
                end
                StGap: begin
                    // One req-low cycle so the producer sees a falling edge.
                    if (list_ack) begin
                        state <= StErr;
                        error <= 1'b1;
                    end else begin
                        state    <= StReq;
                        list_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    list_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_list_stream_reducer.sv
module tb_list_stream_reducer;

    typedef struct {
        bit          done;
        bit          error;
        int unsigned count;
        int unsigned sum;
        int unsigned maxv;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];

    // Main instance: wide counter for the wrap test, short timeout for stalls.
    logic       m_start = 1'b0;
    logic       m_req;
    logic       m_ack = 1'b0;
    logic [7:0] m_value = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_done, m_error;
    logic [8:0] m_count;
    logic [15:0] m_sum;
    logic [7:0] m_max;

    list_stream_reducer #(
        .DATA_W (8), .SUM_W (16), .CNT_W (9), .TIMEOUT (15)
    ) u_main (
        .clock            (clock),
        .reset            (reset),
        .start            (m_start),
        .list_req         (m_req),
        .list_ack         (m_ack),
        .list_value       (m_value),
        .list_value_valid (m_valid),
        .done             (m_done),
        .error            (m_error),
        .count            (m_count),
        .sum              (m_sum),
        .max_val          (m_max)
    );

    // Overflow instance: 2-bit counter.
    logic       o_start = 1'b0;
    logic       o_req;
    logic       o_ack = 1'b0;
    logic [7:0] o_value = 8'h00;
    logic       o_valid = 1'b0;
    logic       o_done, o_error;
    logic [1:0] o_count;
    logic [15:0] o_sum;
    logic [7:0] o_max;

    list_stream_reducer #(
        .DATA_W (8), .SUM_W (16), .CNT_W (2), .TIMEOUT (15)
    ) u_ovf (
        .clock            (clock),
        .reset            (reset),
        .start            (o_start),
        .list_req         (o_req),
        .list_ack         (o_ack),
        .list_value       (o_value),
        .list_value_valid (o_valid),
        .done             (o_done),
        .error            (o_error),
        .count            (o_count),
        .sum              (o_sum),
        .max_val          (o_max)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Producer model for u_main: ack two cycles after req rises.
    logic [7:0] elems[$];
    bit stall = 1'b0;

    initial begin
        forever begin
            @(posedge clock); #1;
            if (m_req && !stall) begin
                @(posedge clock); #1;
                m_ack = 1'b1;
                if (elems.size() > 0) begin
                    m_valid = 1'b1;
                    m_value = elems.pop_front();
                end else begin
                    m_valid = 1'b0;
                    m_value = 8'hA5;
                end
                @(posedge clock); #1;
                m_ack   = 1'b0;
                m_valid = 1'b0;
            end
        end
    end

    // Load the producer and queue the expected result.
    task automatic load_list(input logic [7:0] list[$]);
        res_t r;
        r.done = 1'b1; r.error = 1'b0; r.count = 0; r.sum = 0; r.maxv = 0;
        foreach (list[i]) begin
            elems.push_back(list[i]);
            r.count++;
            r.sum = (r.sum + list[i]) % 65536;
            if (list[i] > r.maxv) r.maxv = list[i];
        end
        exp_q.push_back(r);
    endtask

    task automatic pulse_start(input bit ovf);
        if (ovf) o_start = 1'b1; else m_start = 1'b1;
        @(posedge clock); #1;
        o_start = 1'b0;
        m_start = 1'b0;
    endtask

    // Wait for done/error, then pop the expected result and compare.
    task automatic wait_result(input string tag, input bit ovf, output int gaps);
        int n = 0;
        gaps = 0;
        while (!(ovf ? (o_done | o_error) : (m_done | m_error)) && n < 5000) begin
            if (!(ovf ? o_req : m_req)) gaps++;
            @(posedge clock); #1;
            n++;
        end
        check_eq({tag, "_finished"}, ovf ? (o_done | o_error) : (m_done | m_error), 1);
        check_eq({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            res_t r = exp_q.pop_front();
            check_eq({tag, "_done"},  ovf ? o_done  : m_done,  r.done);
            check_eq({tag, "_error"}, ovf ? o_error : m_error, r.error);
            check_eq({tag, "_count"}, ovf ? 64'(o_count) : 64'(m_count), r.count);
            check_eq({tag, "_sum"},   ovf ? o_sum   : m_sum,   r.sum);
            check_eq({tag, "_max"},   ovf ? o_max   : m_max,   r.maxv);
            check_eq({tag, "_req"},   ovf ? o_req   : m_req,   0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected 0", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int gaps;
        int n;
        int unsigned t0;
        logic [7:0] lst[$];

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req",   m_req,   0);
        check_eq("rst_done",  m_done,  0);
        check_eq("rst_error", m_error, 0);
        check_eq("rst_count", m_count, 0);
        check_eq("rst_sum",   m_sum,   0);
        check_eq("rst_max",   m_max,   0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 3, 7, 5 then end of list
        lst = '{8'd3, 8'd7, 8'd5};
        load_list(lst);
        pulse_start(1'b0);
        wait_result("basic", 1'b0, gaps);
        check_eq("basic_gap_cycles", gaps, 3);

        // Empty list, restarted from DONE
        lst = '{};
        load_list(lst);
        pulse_start(1'b0);
        check_eq("restart_done_clear", m_done, 0);
        wait_result("empty", 1'b0, gaps);

        // Sum wrap: 300 x 255
        lst = '{};
        for (int i = 0; i < 300; i++) lst.push_back(8'd255);
        load_list(lst);
        pulse_start(1'b0);
        wait_result("wrap", 1'b0, gaps);

        // Stall: producer never acks
        stall = 1'b1;
        pulse_start(1'b0);
        check_eq("stall_req_up", m_req, 1);
        t0 = cyc;
        n = 0;
        while (!m_error && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("stall_latency", cyc - t0, 16);
        check_eq("stall_error", m_error, 1);
        check_eq("stall_req", m_req, 0);
        check_eq("stall_done", m_done, 0);

        // Count overflow on the 2-bit instance
        begin
            res_t r;
            r.done = 1'b0; r.error = 1'b1; r.count = 3; r.sum = 3; r.maxv = 1;
            exp_q.push_back(r);
        end
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!o_req && n < 50) begin
                @(posedge clock); #1;
                n++;
            end
            o_ack = 1'b1; o_valid = 1'b1; o_value = 8'd1;
            @(posedge clock); #1;
            o_ack = 1'b0; o_valid = 1'b0;
        end
        wait_result("ovf", 1'b1, gaps);

        // Reset in REQ after two elements, restarted from ERR
        stall = 1'b0;
        elems.push_back(8'd1);
        elems.push_back(8'd2);
        pulse_start(1'b0);
        check_eq("restart_err_clear", m_error, 0);
        n = 0;
        while (m_count != 9'd2 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("mid_count", m_count, 2);
        stall = 1'b1;
        n = 0;
        while (!m_req && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("mid_in_req", m_req, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_req",   m_req,   0);
        check_eq("arst_done",  m_done,  0);
        check_eq("arst_error", m_error, 0);
        check_eq("arst_count", m_count, 0);
        check_eq("arst_sum",   m_sum,   0);
        check_eq("arst_max",   m_max,   0);
        @(posedge clock); #1;
        reset = 1'b0;
        stall = 1'b0;
        @(posedge clock); #1;

        lst = '{8'd1, 8'd2};
        load_list(lst);
        pulse_start(1'b0);
        wait_result("fresh", 1'b0, gaps);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
